// File: rtl/input_circuit_sequencer_if.sv
// rtl/input_circuit_sequencer_if.sv - sample-stream and group handshake bundle for the input sequencer
//
// Signals:
//   in_valid    upstream sample present on datapath D
//   in_ready    sequencer accepts the sample this cycle
//   group_valid segments Q0..Q7 hold a complete group
//   group_ack   downstream consumed the held group
//   grp_idx     index of the group being filled or held
//   frame_done  one-cycle pulse on ack of the last group
// Modports:
//   slave  - the sequencer side
//   master - upstream source plus downstream butterfly stage

interface input_circuit_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic       group_valid;
  logic       group_ack;
  logic [2:0] grp_idx;
  logic       frame_done;

  modport master (
    output in_valid,
    output group_ack,
    input  in_ready,
    input  group_valid,
    input  grp_idx,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  group_ack,
    output in_ready,
    output group_valid,
    output grp_idx,
    output frame_done
  );
endinterface

// File: rtl/input_circuit_sequencer.sv
// rtl/input_circuit_sequencer.sv - control sequencer for the 8-segment FFT input capture circuit
//
// Frames the sample stream into GROUP_COUNT groups of SEG_COUNT samples, hands
// each full group downstream with a valid/ack handshake and parks up to two
// samples in buf_1 (head) / buf_2 (tail) while the segment chain is frozen.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cfg_mode           swap mode requested for the next frame
//   bus (slave)        in_valid/in_ready, group_valid/group_ack, grp_idx, frame_done
//   mode               swap control to the datapath, frozen for a whole frame
//   hold_all_seg       1 = freeze lead buffer and all segments
//   hold_buf_0..2      1 = freeze buffer register
//   in_ctrl_buf_0..2   1 = buffer loads new sample, 0 = loads upstream neighbour
//   pos_hold_ctrl      lead-mux select: 0 = new sample, 1 = buf_1

module input_circuit_sequencer #(
  parameter int SEG_COUNT   = 8,
  parameter int GROUP_COUNT = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_mode,
  input_circuit_sequencer_if.slave        bus,
  output logic                            mode,
  output logic                            hold_all_seg,
  output logic                            hold_buf_0,
  output logic                            hold_buf_1,
  output logic                            hold_buf_2,
  output logic                            in_ctrl_buf_0,
  output logic                            in_ctrl_buf_1,
  output logic                            in_ctrl_buf_2,
  output logic                            pos_hold_ctrl
);

  localparam logic [2:0] SEG_LAST = 3'(SEG_COUNT - 1);
  localparam logic [2:0] GRP_LAST = 3'(GROUP_COUNT - 1);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t     state;
  logic [2:0] seg_cnt;
  logic [2:0] grp_idx_q;
  logic [1:0] cnt;
  logic [1:0] cnt_next;
  logic       mode_reg;
  logic       frame_active;
  logic       group_valid_q;
  logic       frame_done_q;

  logic is_fill;
  logic cnt_is0;
  logic cnt_is1;
  logic cnt_is2;
  logic ready;
  logic acc;
  logic pop;
  logic push;
  logic shift;
  logic buf1_new;
  logic buf1_adv;
  logic buf2_new;
  logic buf2_clr;

  always_comb begin
    is_fill = (state == FILL);
    cnt_is0 = (cnt == 2'd0);
    cnt_is1 = (cnt == 2'd1);
    cnt_is2 = (cnt == 2'd2);

    // The last group's HOLD blocks input so no next-frame sample can be
    // accepted under the outgoing frame's mode.
    if (is_fill) begin
      ready = 1'b1;
    end else begin
      ready = !cnt_is2 && (grp_idx_q != GRP_LAST);
    end

    acc  = bus.in_valid && ready;
    pop  = is_fill && !cnt_is0;
    // In FILL with an empty FIFO the sample goes straight to the lead mux.
    push = acc && !(is_fill && cnt_is0);
    // Buffered samples keep the chain moving even with no upstream sample.
    shift = is_fill && (!cnt_is0 || bus.in_valid);

    // Head takes the new sample when it is the only entry after this cycle
    // (including pop+push at cnt==1), otherwise it advances from the tail.
    buf1_new = push && (cnt_is0 || (cnt_is1 && pop));
    buf1_adv = pop && cnt_is2;
    buf2_new = push && ((cnt_is1 && !pop) || (cnt_is2 && pop));
    buf2_clr = pop && cnt_is2 && !push;

    cnt_next = cnt + 2'(push) - 2'(pop);
  end

  always_comb begin
    bus.in_ready    = !rst && ready;
    bus.group_valid = group_valid_q;
    bus.grp_idx     = grp_idx_q;
    bus.frame_done  = frame_done_q;
    mode            = mode_reg;

    hold_all_seg  = rst || !shift;
    hold_buf_0    = 1'b1;
    in_ctrl_buf_0 = 1'b0;
    hold_buf_1    = rst || !(buf1_new || buf1_adv);
    in_ctrl_buf_1 = !rst && buf1_new;
    hold_buf_2    = rst || !(buf2_new || buf2_clr);
    in_ctrl_buf_2 = !rst && buf2_new;
    // Any buffered sample drains ahead of direct input to keep order.
    pos_hold_ctrl = !rst && !cnt_is0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      seg_cnt       <= 3'd0;
      grp_idx_q     <= 3'd0;
      cnt           <= 2'd0;
      mode_reg      <= 1'b0;
      frame_active  <= 1'b0;
      group_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      cnt          <= cnt_next;

      // Mode tracks cfg_mode between frames and locks on the first accepted sample.
      if (!frame_active) begin
        mode_reg <= cfg_mode;
        if (acc) begin
          frame_active <= 1'b1;
        end
      end

      case (state)
        FILL: begin
          if (shift) begin
            if (seg_cnt == SEG_LAST) begin
              seg_cnt       <= 3'd0;
              state         <= HOLD;
              group_valid_q <= 1'b1;
            end else begin
              seg_cnt <= seg_cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          if (bus.group_ack) begin
            group_valid_q <= 1'b0;
            state         <= FILL;
            if (grp_idx_q == GRP_LAST) begin
              grp_idx_q    <= 3'd0;
              frame_done_q <= 1'b1;
              frame_active <= 1'b0;
            end else begin
              grp_idx_q <= grp_idx_q + 3'd1;
            end
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: doc/input_circuit_sequencer.md
Name: input_circuit_sequencer

Overview:
- Control sequencer for the 8-segment input capture circuit of the 64-point FFT.
- Accepts a valid/ready sample stream and drives segment hold, buffer hold/select, lead-mux select and the real/imag swap mode.
- Frames 64 samples as 8 groups of 8 and hands each full group to the butterfly stage with a valid/ack handshake.
- Parks excess input in a 2-entry buffer (buf_1 = head, buf_2 = tail) while segments are frozen.

Parameters:
SEG_COUNT, 8, samples per group (segment chain length incl. lead buffer)
GROUP_COUNT, 8, groups per frame (SEG_COUNT*GROUP_COUNT = FFT points)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
cfg_mode  input  1  requested swap mode for next frame
in_valid  input  1  upstream sample present on datapath D
in_ready  output  1  sample accepted when in_valid & in_ready
group_valid  output  1  segments Q0..Q7 hold a complete group
group_ack  input  1  downstream consumed group (honoured only when group_valid=1)
grp_idx  output  3  index of group being filled/held, 0..GROUP_COUNT-1
frame_done  output  1  one-cycle pulse on ack of last group
mode  output  1  swap control to datapath
hold_all_seg  output  1  1 = freeze lead buffer and all segments
hold_buf_0, hold_buf_1, hold_buf_2  output  1 each  1 = freeze buffer register
in_ctrl_buf_0, in_ctrl_buf_1, in_ctrl_buf_2  output  1 each  1 = buffer loads new sample, 0 = loads upstream neighbour (buf_2 upstream is zero)
pos_hold_ctrl  output  1  lead-mux select: 0 = new sample, 1 = buf_1

Behaviour:
- Registers: state {FILL, HOLD}, seg_cnt[2:0], grp_idx, cnt (FIFO occupancy 0..2), mode_reg, frame_active, group_valid, frame_done.
- Reset: state=FILL; seg_cnt=0; grp_idx=0; cnt=0; mode=0; frame_active=0; group_valid=0; frame_done=0.
- Reset mid-frame discards everything; no group_valid or frame_done follows.
- Reset decodes: hold_all_seg=1, all hold_buf_x=1, all in_ctrl_x=0, pos_hold_ctrl=0, in_ready=0.
- in_ready: FILL -> 1; HOLD -> (cnt<2) & ~(grp_idx==GROUP_COUNT-1). The last group's HOLD blocks input so no next-frame sample is swapped with the old mode.
- acc = in_valid & in_ready.
- pop = FILL & cnt>0.
- push = acc & ~(FILL & cnt==0); push never occurs with cnt==2 & ~pop.
- shift = FILL & (cnt>0 | in_valid); hold_all_seg = ~shift.
- pos_hold_ctrl = (cnt>0), so buffered samples always drain before direct input and order is preserved.
- buf_1 control:
  - load new (hold=0, sel=1) if push & (cnt==0 | (cnt==1 & pop));
  - load buf_2 (hold=0, sel=0) if pop & cnt==2;
  - else hold=1.
- buf_2 control:
  - load new (sel=1) if push & ((cnt==1 & ~pop) | (cnt==2 & pop));
  - clear (hold=0, sel=0) if pop & cnt==2 & ~push;
  - else hold=1.
- buf_0 is reserved: hold_buf_0=1, in_ctrl_buf_0=0 permanently.
- cnt_next = cnt + push - pop.
- FILL:
  - each shift increments seg_cnt.
  - On the shift with seg_cnt==SEG_COUNT-1: seg_cnt->0, state->HOLD, group_valid registered 1.
  - First-word latency: group_valid rises the cycle after the 8th shift.
- HOLD:
  - segments frozen; accepted samples enter FIFO (max 2).
  - On group_ack: group_valid->0, state->FILL next cycle, grp_idx wraps modulo GROUP_COUNT.
  - If grp_idx was GROUP_COUNT-1: frame_done pulses 1 cycle, frame_active->0.
- group_ack outside HOLD is ignored.
- Mode: while frame_active=0, mode_reg <= cfg_mode every cycle. First acc sets frame_active and mode_reg stays frozen until frame end; cfg_mode changes mid-frame have no effect.
- Simultaneous pop+push at cnt==1 routes the new sample straight into buf_1 (head) the same cycle buf_1 feeds the lead mux.

Test Plan:
- Reset, then stream 8 samples back-to-back with in_valid=1 -> hold_all_seg=0 for 8 cycles, group_valid=1 on cycle 9, grp_idx=0, Q0 = first sample.
- Hold group 0 for 5 cycles with in_valid=1 -> exactly 2 samples accepted (cnt=2), in_ready=0 afterwards. After ack: pos_hold_ctrl=1 for 2 cycles, shift order = buffered then new.
- Full 64-sample frame with random 0/1 in_valid and ack delays 0..4 -> 8 group_valid handshakes, grp_idx 0..7, one frame_done after 8th ack, sample order intact.
- cfg_mode=1 before first sample, toggled to 0 mid-frame -> mode=1 all frame; next frame mode=0. in_ready=0 throughout HOLD of group 7.
- cnt=1 in FILL with in_valid=1 -> buf_1 in_ctrl=1 with hold=0, buf_2 holds, cnt stays 1.
- Assert rst during HOLD of group 3 -> group_valid=0, cnt=0, grp_idx=0 next cycle. A subsequent 8 samples produce group 0.
